// File: rtl/elevator_ctrl.sv
// elevator_ctrl
//   Control FSM for the elevator datapath using a collective (SCAN) policy:
//   keep travelling in the remembered direction while requests remain ahead,
//   reverse when none remain, and idle when there are no requests anywhere.
//
// Parameters
//   N              number of floors (width of the one-hot floor bus i)
//   TRAVEL_CYCLES  cycles spent between floors before each step pulse (>=1)
//   DOOR_CYCLES    cycles open is held high per door opening (>=1)
//
// Ports
//   clk             in   rising-edge clock
//   rst             in   synchronous reset, active-high
//   request_i       in   pending request at the current floor
//   request_j_gt_i  in   pending request at some floor above
//   request_j_lt_i  in   pending request at some floor below
//   i               in   one-hot current floor (i[0] = ground)
//   door_hold       in   door-hold button; restarts the door timer while open
//   open            out  door open; datapath clears the current-floor request
//   up              out  1-cycle pulse: move one floor up
//   down            out  1-cycle pulse: move one floor down
//   dir_up          out  remembered travel direction (1 = up)
//   busy            out  high in every state except IDLE
module elevator_ctrl #(
    parameter int N             = 5,
    parameter int TRAVEL_CYCLES = 3,
    parameter int DOOR_CYCLES   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         request_i,
    input  logic         request_j_gt_i,
    input  logic         request_j_lt_i,
    input  logic [N-1:0] i,
    input  logic         door_hold,
    output logic         open,
    output logic         up,
    output logic         down,
    output logic         dir_up,
    output logic         busy
);

    localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0] DOOR_LAST   = DW'(DOOR_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        DECIDE,
        MOVE_UP,
        MOVE_DOWN,
        ARRIVE,
        DOOR_OPEN
    } state_t;

    state_t        state, state_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic [DW-1:0] dcnt, dcnt_n;
    logic          open_n, up_n, down_n, dir_n, busy_n;

    // Only the end floors matter to the step guards; the middle bits are
    // folded here so the full bus is consumed.
    logic unused_floor_bits;
    assign unused_floor_bits = ^i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            tcnt   <= '0;
            dcnt   <= '0;
            open   <= 1'b0;
            up     <= 1'b0;
            down   <= 1'b0;
            dir_up <= 1'b1;
            busy   <= 1'b0;
        end else begin
            state  <= state_n;
            tcnt   <= tcnt_n;
            dcnt   <= dcnt_n;
            open   <= open_n;
            up     <= up_n;
            down   <= down_n;
            dir_up <= dir_n;
            busy   <= busy_n;
        end
    end

    always_comb begin
        state_n = state;
        tcnt_n  = tcnt;
        dcnt_n  = dcnt;
        open_n  = 1'b0;
        up_n    = 1'b0;
        down_n  = 1'b0;
        dir_n   = dir_up;

        case (state)
            IDLE: begin
                if (request_i) begin
                    state_n = DOOR_OPEN;
                end else if (request_j_gt_i || request_j_lt_i) begin
                    state_n = DECIDE;
                end
            end

            DECIDE: begin
                tcnt_n = '0;
                dcnt_n = '0;
                if (request_i) begin
                    state_n = DOOR_OPEN;
                end else if (dir_up && request_j_gt_i) begin
                    state_n = MOVE_UP;
                end else if (!dir_up && request_j_lt_i) begin
                    state_n = MOVE_DOWN;
                end else if (request_j_gt_i) begin
                    state_n = MOVE_UP;
                    dir_n   = 1'b1;
                end else if (request_j_lt_i) begin
                    state_n = MOVE_DOWN;
                    dir_n   = 1'b0;
                end else begin
                    state_n = IDLE;
                end
            end

            // The pulse is issued together with the move into ARRIVE, so the
            // datapath sees it during ARRIVE and DECIDE sees the new floor.
            MOVE_UP: begin
                if (tcnt == TRAVEL_LAST) begin
                    tcnt_n = '0;
                    if (i[N-1]) begin
                        state_n = DECIDE;
                    end else begin
                        up_n    = 1'b1;
                        state_n = ARRIVE;
                    end
                end else begin
                    tcnt_n = tcnt + TW'(1);
                end
            end

            MOVE_DOWN: begin
                if (tcnt == TRAVEL_LAST) begin
                    tcnt_n = '0;
                    if (i[0]) begin
                        state_n = DECIDE;
                    end else begin
                        down_n  = 1'b1;
                        state_n = ARRIVE;
                    end
                end else begin
                    tcnt_n = tcnt + TW'(1);
                end
            end

            ARRIVE: begin
                state_n = DECIDE;
            end

            // First cycle in DOOR_OPEN raises open; dcnt then counts the
            // open cycles. door_hold restarts the count on any open cycle.
            DOOR_OPEN: begin
                if (!open) begin
                    open_n = 1'b1;
                    dcnt_n = '0;
                end else if (door_hold || (dcnt == DOOR_LAST && request_i)) begin
                    open_n = 1'b1;
                    dcnt_n = '0;
                end else if (dcnt == DOOR_LAST) begin
                    dcnt_n  = '0;
                    state_n = DECIDE;
                end else begin
                    open_n = 1'b1;
                    dcnt_n = dcnt + DW'(1);
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_elevator_ctrl.sv
// tb_elevator_ctrl
//   Self-checking bench for elevator_ctrl (N=5, TRAVEL_CYCLES=3, DOOR_CYCLES=4).
//   The bench plays the datapath (floor position, request table) and runs a
//   procedural model of the SCAN policy that predicts every output cycle.
module tb_elevator_ctrl;

    localparam int N = 5;
    localparam int T = 3;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         request_i, gt, lt, door_hold;
    logic [N-1:0] i_bus;
    logic         open, up, down, dir_up, busy;

    elevator_ctrl #(.N(N), .TRAVEL_CYCLES(T), .DOOR_CYCLES(D)) dut (
        .clk            (clk),
        .rst            (rst),
        .request_i      (request_i),
        .request_j_gt_i (gt),
        .request_j_lt_i (lt),
        .i              (i_bus),
        .door_hold      (door_hold),
        .open           (open),
        .up             (up),
        .down           (down),
        .dir_up         (dir_up),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // environment / model state
    int           n_checks = 0;
    int           n_pass   = 0;
    int           cyc      = 0;
    int           floor_no = 0;
    logic [N-1:0] req      = '0;
    logic         force_gt = 1'b0;
    logic         rand_mode = 1'b0;
    int           hold_budget = 0;
    logic         m_dir    = 1'b1;
    logic         m_idle   = 1'b1;   // model position: 1 = IDLE, 0 = DECIDE
    logic         prev_open = 1'b0;
    int           last_pulse = -1;
    int           n_up = 0, n_down = 0, open_run = 0, first_open_cyc = -1;
    int           door_q[$];
    int           pulse_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic drive_flags();
        logic g, l;
        g = force_gt;
        l = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (req[k] && k > floor_no) g = 1'b1;
            if (req[k] && k < floor_no) l = 1'b1;
        end
        i_bus = '0;
        i_bus[floor_no] = 1'b1;
        request_i = req[floor_no];
        gt = g;
        lt = l;
    endtask

    // One clock: check predicted outputs, then let the datapath react.
    task automatic step(input logic eo, input logic eu, input logic ed,
                        input logic eb, input string tag);
        @(posedge clk);
        #1;
        cyc++;
        chk(tag, 32'({open, up, down, busy, dir_up}), 32'({eo, eu, ed, eb, m_dir}));
        if (up === 1'b1 || down === 1'b1) begin
            if (last_pulse >= 0) chk("pulse_gap", 32'(cyc - last_pulse >= T + 2), 32'd1);
            last_pulse = cyc;
            pulse_q.push_back(cyc);
        end
        if (up === 1'b1) begin
            n_up++;
            if (floor_no < N - 1) floor_no++;
        end
        if (down === 1'b1) begin
            n_down++;
            if (floor_no > 0) floor_no--;
        end
        if (open === 1'b1) begin
            open_run++;
            req[floor_no] = 1'b0;
            if (!prev_open) begin
                first_open_cyc = cyc;
                door_q.push_back(floor_no);
            end
        end
        prev_open = (open === 1'b1);
        if (hold_budget > 0 && open === 1'b1) begin
            door_hold = 1'b1;
            hold_budget--;
        end else if (rand_mode) begin
            door_hold = ($urandom_range(0, 7) == 0);
        end else begin
            door_hold = 1'b0;
        end
        if (rand_mode && $urandom_range(0, 5) == 0) req[$urandom_range(0, N - 1)] = 1'b1;
        drive_flags();
    endtask

    // Door opening: one entry cycle, then open cycles until the countdown of
    // remaining open cycles runs out; ends in the following DECIDE cycle.
    task automatic do_door();
        int left;
        step(1'b0, 1'b0, 1'b0, 1'b1, "door_entry");
        left = D;
        do begin
            step(1'b1, 1'b0, 1'b0, 1'b1, "door_open");
            if (door_hold || (left == 1 && request_i)) left = D;
            else left--;
        end while (left > 0);
        step(1'b0, 1'b0, 1'b0, 1'b1, "door_close");
        m_idle = 1'b0;
    endtask

    // One floor of travel; ends in the DECIDE cycle after arrival or block.
    task automatic do_move(input logic go_up);
        logic blocked;
        repeat (T) step(1'b0, 1'b0, 1'b0, 1'b1, "travel");
        blocked = go_up ? (floor_no == N - 1) : (floor_no == 0);
        if (blocked) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, "blocked");
        end else begin
            step(1'b0, go_up, !go_up, 1'b1, go_up ? "up_pulse" : "down_pulse");
            step(1'b0, 1'b0, 1'b0, 1'b1, "arrive");
        end
        m_idle = 1'b0;
    endtask

    task automatic model_run(input int limit, input logic stop_idle);
        int start;
        start = cyc;
        while (cyc - start < limit) begin
            if (m_idle) begin
                if (stop_idle && !request_i && !gt && !lt) break;
                if (request_i) begin
                    do_door();
                end else if (gt || lt) begin
                    step(1'b0, 1'b0, 1'b0, 1'b1, "idle_wake");
                    m_idle = 1'b0;
                end else begin
                    step(1'b0, 1'b0, 1'b0, 1'b0, "idle");
                end
            end else begin
                if (request_i) do_door();
                else if (m_dir && gt) do_move(1'b1);
                else if (!m_dir && lt) do_move(1'b0);
                else if (gt) begin m_dir = 1'b1; do_move(1'b1); end
                else if (lt) begin m_dir = 1'b0; do_move(1'b0); end
                else begin
                    step(1'b0, 1'b0, 1'b0, 1'b0, "to_idle");
                    m_idle = 1'b1;
                end
            end
        end
    endtask

    task automatic clear_stats();
        n_up = 0;
        n_down = 0;
        open_run = 0;
        first_open_cyc = -1;
        door_q.delete();
        pulse_q.delete();
    endtask

    task automatic reset_pulse(input string tag);
        rst = 1'b1;
        m_dir = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, tag);
        step(1'b0, 1'b0, 1'b0, 1'b0, tag);
        req = '0;
        drive_flags();
        rst = 1'b0;
        m_idle = 1'b1;
        last_pulse = -1;
    endtask

    initial begin
        rst = 1'b1;
        door_hold = 1'b0;
        drive_flags();

        // power-on reset
        reset_pulse("reset_state");

        // reset in the middle of an upward move
        floor_no = 0; req = '0; req[3] = 1'b1; drive_flags();
        step(1'b0, 1'b0, 1'b0, 1'b1, "t1_decide");
        step(1'b0, 1'b0, 1'b0, 1'b1, "t1_move0");
        step(1'b0, 1'b0, 1'b0, 1'b1, "t1_move1");
        reset_pulse("t1_reset");

        // ground floor to floor 3
        clear_stats();
        floor_no = 0; req[3] = 1'b1; drive_flags();
        model_run(200, 1'b1);
        chk("t2_up_pulses", 32'(n_up), 32'd3);
        if (pulse_q.size() == 3) begin
            chk("t2_gap_a", 32'(pulse_q[1] - pulse_q[0]), 32'd5);
            chk("t2_gap_b", 32'(pulse_q[2] - pulse_q[1]), 32'd5);
        end
        chk("t2_open_cycles", 32'(open_run), 32'd4);
        chk("t2_floor", 32'(floor_no), 32'd3);
        chk("t2_busy", 32'(busy), 32'd0);

        // at floor 2 going up, requests at 4 and 0
        clear_stats();
        floor_no = 2; req[4] = 1'b1; req[0] = 1'b1; drive_flags();
        model_run(300, 1'b1);
        chk("t3_doors", 32'(door_q.size()), 32'd2);
        if (door_q.size() == 2) begin
            chk("t3_first_stop", 32'(door_q[0]), 32'd4);
            chk("t3_second_stop", 32'(door_q[1]), 32'd0);
        end
        chk("t3_up_pulses", 32'(n_up), 32'd2);
        chk("t3_down_pulses", 32'(n_down), 32'd4);
        chk("t3_dir", 32'(dir_up), 32'd0);
        reset_pulse("t3_reset_dir");

        // door hold for 6 cycles at floor 1
        clear_stats();
        floor_no = 1; req[1] = 1'b1; hold_budget = 6; drive_flags();
        model_run(100, 1'b1);
        chk("t4_open_cycles", 32'(open_run), 32'd10);

        // top floor with an upward request forced: never step up
        clear_stats();
        floor_no = 4; force_gt = 1'b1; drive_flags();
        model_run(40, 1'b0);
        chk("t5_no_up", 32'(n_up), 32'd0);
        force_gt = 1'b0; drive_flags();
        model_run(50, 1'b1);
        chk("t5_idle", 32'(busy), 32'd0);

        // request at the current floor while idle
        clear_stats();
        floor_no = 2; req[2] = 1'b1; drive_flags();
        begin
            int req_cyc;
            req_cyc = cyc;
            model_run(50, 1'b1);
            chk("t6_open_latency", 32'(first_open_cyc - req_cyc), 32'd2);
        end
        chk("t6_no_steps", 32'(n_up + n_down), 32'd0);

        // random requests and door-hold presses
        clear_stats();
        rand_mode = 1'b1;
        repeat (4) model_run(250, 1'b0);
        rand_mode = 1'b0;
        door_hold = 1'b0;
        drive_flags();
        model_run(800, 1'b1);
        chk("drain_idle", 32'(busy), 32'd0);
        chk("drain_no_requests", 32'(req), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
